// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel lane receiver: COM-based byte alignment, lock counting and
// payload extraction, with COM/PAD symbols filtered out of the data path.
//
// state  | meaning
// SEARCH | hunting for COM at any bit offset; bit_cnt not used
// ALIGN  | byte framing fixed by the first COM; counting consecutive COMs
// ACTIVE | locked; non-COM/PAD bytes are delivered on data_out
module serial_paralelo_rx #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter logic [7:0] PAD      = 8'h7C,
  parameter int         COM_LOCK = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int            CW     = $clog2(COM_LOCK + 1);
  localparam logic [CW-1:0] LOCK_V = CW'(COM_LOCK);
  localparam logic [CW-1:0] ONE_V  = CW'(1);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    ACTIVE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [7:0]    r_sr;
  logic [7:0]    w_sr_next;
  logic [2:0]    r_bit_cnt;
  logic [2:0]    w_bit_cnt_next;
  logic [CW-1:0] r_com_cnt;
  logic [CW-1:0] w_com_cnt_next;
  logic [CW-1:0] w_com_inc;
  logic [7:0]    r_data;
  logic [7:0]    w_data_next;
  logic          r_valid;
  logic          w_valid_next;
  logic          r_strobe;
  logic          w_strobe_next;
  logic          r_active;
  logic          w_active_next;
  logic          w_boundary;

  assign w_sr_next  = {r_sr[6:0], data_in};
  assign w_boundary = (r_bit_cnt == 3'd7);
  // Saturating increment so the lock counter can never wrap back below COM_LOCK
  assign w_com_inc  = (r_com_cnt < LOCK_V) ? (r_com_cnt + ONE_V) : r_com_cnt;

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt + 3'd1;
    w_com_cnt_next = r_com_cnt;
    w_data_next    = r_data;
    w_valid_next   = 1'b0;
    w_strobe_next  = 1'b0;
    w_active_next  = r_active;
    case (r_state)
      SEARCH: begin
        w_bit_cnt_next = r_bit_cnt;
        if (w_sr_next == COM) begin
          w_bit_cnt_next = 3'd0;
          w_com_cnt_next = ONE_V;
          w_state_next   = ALIGN;
          if (ONE_V == LOCK_V) begin
            w_state_next  = ACTIVE;
            w_active_next = 1'b1;
          end
        end
      end
      ALIGN: begin
        if (w_boundary) begin
          w_strobe_next = 1'b1;
          if (w_sr_next == COM) begin
            w_com_cnt_next = w_com_inc;
            if (w_com_inc == LOCK_V) begin
              w_state_next  = ACTIVE;
              w_active_next = 1'b1;
            end
          end else begin
            w_state_next   = SEARCH;
            w_com_cnt_next = '0;
          end
        end
      end
      ACTIVE: begin
        // Framing is frozen here: a COM straddling two bytes is just payload bits
        if (w_boundary) begin
          w_strobe_next = 1'b1;
          if ((w_sr_next != COM) && (w_sr_next != PAD)) begin
            w_data_next  = w_sr_next;
            w_valid_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_sr      <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= '0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sr      <= w_sr_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_com_cnt <= w_com_cnt_next;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_strobe  <= w_strobe_next;
      r_active  <= w_active_next;
    end
  end

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign byte_strobe = r_strobe;
  assign active      = r_active;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: locking, resync, offset alignment,
// COM/PAD filtering, straddling COM immunity and asynchronous reset.
module tb_serial_paralelo_rx;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int n_checks;
  int n_errors;
  int cnt_strobe;
  int cnt_valid;

  serial_paralelo_rx dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let the next rising edge sample it, then look 1 time unit later
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    if (byte_strobe) cnt_strobe++;
    if (valid_out) cnt_valid++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cnt_strobe = 0;
    cnt_valid  = 0;
    reset      = 1'b1;
    data_in    = 1'b0;
    repeat (3) @(posedge clk_32f);
    #1;
    chk("rst_data", {24'h0, data_out}, 32'h00);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_strobe", {31'h0, byte_strobe}, 32'h0);
    chk("rst_active", {31'h0, active}, 32'h0);
    reset = 1'b0;

    // Four COMs lock the lane, then two payload bytes
    send_byte(8'hBC);
    chk("lock_first_com_strobe", {31'h0, byte_strobe}, 32'h0);
    send_byte(8'hBC);
    chk("lock_second_com_strobe", {31'h0, byte_strobe}, 32'h1);
    send_byte(8'hBC);
    chk("lock_active_after3", {31'h0, active}, 32'h0);
    send_byte(8'hBC);
    chk("lock_active_after4", {31'h0, active}, 32'h1);
    chk("lock_valid_on_com", {31'h0, valid_out}, 32'h0);
    cnt_strobe = 0;
    cnt_valid  = 0;
    send_byte(8'h12);
    chk("pay_valid_12", {31'h0, valid_out}, 32'h1);
    chk("pay_data_12", {24'h0, data_out}, 32'h12);
    send_bit(1'b0);
    chk("pay_valid_drop", {31'h0, valid_out}, 32'h0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    chk("pay_valid_34", {31'h0, valid_out}, 32'h1);
    chk("pay_data_34", {24'h0, data_out}, 32'h34);
    chk("pay_strobe_count", cnt_strobe, 2);
    chk("pay_valid_count", cnt_valid, 2);

    // COM/PAD filtering while active
    cnt_strobe = 0;
    cnt_valid  = 0;
    send_byte(8'hBC);
    chk("filt_hold_after_com", {24'h0, data_out}, 32'h34);
    send_byte(8'h7C);
    send_byte(8'hEE);
    send_byte(8'h7C);
    chk("filt_strobe_count", cnt_strobe, 4);
    chk("filt_valid_count", cnt_valid, 1);
    chk("filt_data_hold", {24'h0, data_out}, 32'hEE);

    // 5E 3C carries BC across the boundary; framing must not move
    send_byte(8'h5E);
    chk("straddle_5e", {24'h0, data_out}, 32'h5E);
    send_byte(8'h3C);
    chk("straddle_3c", {24'h0, data_out}, 32'h3C);
    chk("straddle_valid", {31'h0, valid_out}, 32'h1);

    // Asynchronous reset mid-byte while active
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_data", {24'h0, data_out}, 32'h00);
    chk("arst_active", {31'h0, active}, 32'h0);
    chk("arst_strobe", {31'h0, byte_strobe}, 32'h0);
    chk("arst_valid", {31'h0, valid_out}, 32'h0);
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("arst_relock_after3", {31'h0, active}, 32'h0);
    send_byte(8'hBC);
    chk("arst_relock_after4", {31'h0, active}, 32'h1);

    // Broken COM run sends the lane back to SEARCH
    do_reset();
    cnt_valid = 0;
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    send_byte(8'h55);
    chk("brk_strobe_on_55", {31'h0, byte_strobe}, 32'h1);
    chk("brk_active_after_55", {31'h0, active}, 32'h0);
    chk("brk_no_payload", cnt_valid, 0);
    send_byte(8'hBC);
    chk("brk_search_no_strobe", {31'h0, byte_strobe}, 32'h0);
    send_byte(8'hBC); send_byte(8'hBC);
    chk("brk_active_after3", {31'h0, active}, 32'h0);
    send_byte(8'hBC);
    chk("brk_active_after4", {31'h0, active}, 32'h1);

    // Three garbage bits ahead of the COM run
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("off_active", {31'h0, active}, 32'h1);
    send_byte(8'hA5);
    chk("off_data", {24'h0, data_out}, 32'hA5);
    chk("off_valid", {31'h0, valid_out}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
